// File: rtl/maze_pkg.sv
// Shared constants for the MAZE router: port indices, packet geometry and
// a one-hot test used to qualify route requests.
package maze_pkg;

    localparam int NUM_PORTS = 5;
    localparam int REQ_W     = 5;
    localparam int PKT_W     = 23;
    localparam int QOS_POS   = 8;

    localparam int DIR_N = 0;
    localparam int DIR_W = 1;
    localparam int DIR_S = 2;
    localparam int DIR_E = 3;
    localparam int DIR_B = 4;

    typedef logic [NUM_PORTS-1:0] port_mask_t;

    function automatic logic is_onehot(input port_mask_t v);
        return (v != 5'b00000) && ((v & (v - 5'd1)) == 5'b00000);
    endfunction

endpackage

// File: rtl/switch_allocator_if.sv
// Input-head and output-link bundle of the switch allocator. The allocator
// sits on the slave side; the router fabric / bench is the master.
interface switch_allocator_if;
    import maze_pkg::*;

    logic [NUM_PORTS-1:0]       in_valid;
    logic [NUM_PORTS*REQ_W-1:0] in_req;
    logic [NUM_PORTS*PKT_W-1:0] in_pkt;
    logic [NUM_PORTS-1:0]       in_pop;
    logic [NUM_PORTS-1:0]       out_valid;
    logic [NUM_PORTS*PKT_W-1:0] out_pkt;
    logic [NUM_PORTS-1:0]       out_ready;
    logic [NUM_PORTS-1:0]       req_err;

    modport master (
        output in_valid, in_req, in_pkt, out_ready,
        input  in_pop, out_valid, out_pkt, req_err
    );

    modport slave (
        input  in_valid, in_req, in_pkt, out_ready,
        output in_pop, out_valid, out_pkt, req_err
    );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin picker: first set request at or above ptr, wrapping 4 -> 0.
module rr_arbiter
    import maze_pkg::*;
(
    input  logic [NUM_PORTS-1:0] req,
    input  logic [2:0]           ptr,
    output logic [NUM_PORTS-1:0] gnt,
    output logic                 gnt_valid
);

    logic [2:0] base_s;
    logic [3:0] sum_s;
    logic [3:0] idx_s;
    logic       hit_s;

    // Out-of-range pointers fall back to 0 so the search index stays in bounds.
    always_comb begin
        gnt       = 5'b00000;
        gnt_valid = 1'b0;
        sum_s     = 4'd0;
        idx_s     = 4'd0;
        hit_s     = 1'b0;
        base_s    = (ptr >= 3'(NUM_PORTS)) ? 3'd0 : ptr;
        for (int k = 0; k < NUM_PORTS; k++) begin
            sum_s            = {1'b0, base_s} + 4'(k);
            idx_s            = (sum_s >= 4'(NUM_PORTS)) ? (sum_s - 4'(NUM_PORTS)) : sum_s;
            hit_s            = !gnt_valid && req[idx_s[2:0]];
            gnt[idx_s[2:0]]  = gnt[idx_s[2:0]] | hit_s;
            gnt_valid        = gnt_valid | hit_s;
        end
    end

endmodule

// File: rtl/switch_allocator.sv
// Per-output QoS / starvation-guarded round-robin allocator with a one-entry
// registered output stage per port.
module switch_allocator
    import maze_pkg::*;
#(
    parameter int STARVE_MAX = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    switch_allocator_if.slave    bus
);

    logic [NUM_PORTS-1:0]                req_ok_s;
    logic [NUM_PORTS-1:0]                qos_s;
    logic [NUM_PORTS-1:0][NUM_PORTS-1:0] pop_mat_s;
    logic [NUM_PORTS-1:0]                pop_s;

    // Qualify requests and flag malformed route vectors; reset gates the error pulse.
    always_comb begin
        req_ok_s    = 5'b00000;
        qos_s       = 5'b00000;
        bus.req_err = 5'b00000;
        for (int i = 0; i < NUM_PORTS; i++) begin
            req_ok_s[i]    = bus.in_valid[i] && is_onehot(bus.in_req[i*REQ_W +: REQ_W]);
            qos_s[i]       = bus.in_pkt[i*PKT_W + QOS_POS];
            bus.req_err[i] = rst_n && bus.in_valid[i] && !is_onehot(bus.in_req[i*REQ_W +: REQ_W]);
        end
    end

    // Each input targets one output, so the per-output grants never overlap.
    always_comb begin
        pop_s = 5'b00000;
        for (int o = 0; o < NUM_PORTS; o++) begin
            pop_s = pop_s | pop_mat_s[o];
        end
        bus.in_pop = pop_s;
    end

    for (genvar o = 0; o < NUM_PORTS; o++) begin : g_out
        logic [NUM_PORTS-1:0] cand_s;
        logic [NUM_PORTS-1:0] q0_s;
        logic [NUM_PORTS-1:0] q1_s;
        logic [NUM_PORTS-1:0] mask_s;
        logic [NUM_PORTS-1:0] gnt_s;
        logic                 gnt_valid_s;
        logic                 open_s;
        logic                 grant_s;
        logic [2:0]           win_idx_s;
        logic                 win_qos_s;
        logic [PKT_W-1:0]     win_pkt_s;
        logic                 valid_r;
        logic [PKT_W-1:0]     pkt_r;
        logic [2:0]           ptr_r;
        logic [3:0]           starve_r;

        // Build the requester set and apply the starvation / QoS priority mask.
        always_comb begin
            cand_s = 5'b00000;
            for (int i = 0; i < NUM_PORTS; i++) begin
                cand_s[i] = req_ok_s[i] && bus.in_req[i*REQ_W + o];
            end
            q0_s = cand_s & ~qos_s;
            q1_s = cand_s & qos_s;
            if ((starve_r == 4'(STARVE_MAX)) && (q0_s != 5'b00000)) begin
                mask_s = q0_s;
            end else if (q1_s != 5'b00000) begin
                mask_s = q1_s;
            end else begin
                mask_s = cand_s;
            end
        end

        rr_arbiter u_arb (
            .req       (mask_s),
            .ptr       (ptr_r),
            .gnt       (gnt_s),
            .gnt_valid (gnt_valid_s)
        );

        assign open_s  = !valid_r || bus.out_ready[o];
        assign grant_s = rst_n && open_s && gnt_valid_s;

        // One-hot grant to winner index, QoS bit and packet without priority logic.
        always_comb begin
            win_idx_s = 3'd0;
            win_qos_s = 1'b0;
            win_pkt_s = {PKT_W{1'b0}};
            for (int i = 0; i < NUM_PORTS; i++) begin
                win_idx_s = win_idx_s | (gnt_s[i] ? 3'(i) : 3'd0);
                win_qos_s = win_qos_s | (gnt_s[i] & qos_s[i]);
                win_pkt_s = win_pkt_s | ({PKT_W{gnt_s[i]}} & bus.in_pkt[i*PKT_W +: PKT_W]);
            end
        end

        assign pop_mat_s[o] = grant_s ? gnt_s : 5'b00000;

        // Output register, round-robin pointer and starvation counter.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                valid_r  <= 1'b0;
                pkt_r    <= {PKT_W{1'b0}};
                ptr_r    <= 3'd0;
                starve_r <= 4'd0;
            end else if (grant_s) begin
                valid_r <= 1'b1;
                pkt_r   <= win_pkt_s;
                ptr_r   <= (win_idx_s == 3'd4) ? 3'd0 : (win_idx_s + 3'd1);
                if (win_qos_s && (q0_s != 5'b00000)) begin
                    starve_r <= (starve_r >= 4'(STARVE_MAX)) ? starve_r : (starve_r + 4'd1);
                end else begin
                    starve_r <= 4'd0;
                end
            end else if (bus.out_ready[o]) begin
                valid_r <= 1'b0;
            end else begin
                valid_r <= valid_r;
            end
        end

        assign bus.out_valid[o]                 = valid_r;
        assign bus.out_pkt[o*PKT_W +: PKT_W]    = pkt_r;
    end

endmodule
